// File: rtl/fetch_sequencer.sv
// Program-counter sequencer for the instruction ROM: start, sequential fetch, branch, stall, halt.
// Optional FETCH_CYCLE_COUNT_EN builds a saturating RUN-cycle counter; otherwise CycleCount is tied to 0.
module fetch_sequencer #(
  parameter int AW = 11,
  parameter int CW = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [AW-1:0] StartAddr,
  input  logic          Stall,
  input  logic          BranchEn,
  input  logic [AW-1:0] BranchTarget,
  input  logic          HaltReq,
  output logic [AW-1:0] InstAddress,
  output logic          Running,
  output logic          Done,
  output logic          Fault,
  output logic [CW-1:0] CycleCount,
  output logic [1:0]    state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] pc, pc_nxt;
  logic [AW:0]   pc_inc;
  logic          load, wrap, count_en;

  // Start is a level sampled at the rising edge; it is accepted only in IDLE or HALTED,
  // and acceptance is the single edge at which the PC loads and the status flips to RUN.
  assign pc_inc = {1'b0, pc} + {{AW{1'b0}}, 1'b1};

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    load      = 1'b0;
    wrap      = 1'b0;
    count_en  = 1'b0;
    case (state)
      IDLE, HALTED: begin
        if (Start) begin
          state_nxt = RUN;
          pc_nxt    = StartAddr;
          load      = 1'b1;
        end
      end
      RUN: begin
        if (HaltReq) begin
          state_nxt = HALTED;
        end else begin
          count_en = 1'b1;
          if (Stall) begin
            pc_nxt = pc;
          end else if (BranchEn) begin
            pc_nxt = BranchTarget;
          end else begin
            pc_nxt = pc_inc[AW-1:0];
            wrap   = pc_inc[AW];
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      pc    <= '0;
      Fault <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (load)      Fault <= 1'b0;
      else if (wrap) Fault <= 1'b1;
    end
  end

`ifdef FETCH_CYCLE_COUNT_EN
  logic [CW-1:0] cycle_cnt;

  // The halting edge itself is not counted, so the value frozen in HALTED is the work done.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cycle_cnt <= '0;
    end else if (load) begin
      cycle_cnt <= '0;
    end else if (count_en && (cycle_cnt != {CW{1'b1}})) begin
      cycle_cnt <= cycle_cnt + CW'(1);
    end
  end

  assign CycleCount = cycle_cnt;
`else
  assign CycleCount = '0;
`endif

  assign InstAddress = pc;
  assign Running     = (state == RUN);
  assign Done        = (state == HALTED);
  assign state_dbg   = state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: a reference model predicts each cycle into exp_q,
// and the DUT outputs are popped and compared one cycle after each drive.
module tb_fetch_sequencer;
  localparam int AW = 11;
  localparam int CW = 16;
  localparam int W  = CW + AW + 5;

  logic          clk, rst_n;
  logic          start, stall, branch_en, halt_req;
  logic [AW-1:0] start_addr, branch_target;
  logic [AW-1:0] inst_address;
  logic          running, done, fault;
  logic [CW-1:0] cycle_count;
  logic [1:0]    state_dbg;

  logic [W-1:0]  exp_q[$];
  int            checks   = 0;
  int            failures = 0;

  // Reference model state: 0 = idle, 1 = run, 2 = halted
  int            m_state;
  logic [AW-1:0] m_pc;
  logic          m_fault;
  logic [CW-1:0] m_cnt;

  fetch_sequencer #(.AW(AW), .CW(CW)) dut (
    .Clk         (clk),
    .Reset       (rst_n),
    .Start       (start),
    .StartAddr   (start_addr),
    .Stall       (stall),
    .BranchEn    (branch_en),
    .BranchTarget(branch_target),
    .HaltReq     (halt_req),
    .InstAddress (inst_address),
    .Running     (running),
    .Done        (done),
    .Fault       (fault),
    .CycleCount  (cycle_count),
    .state_dbg   (state_dbg)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [CW-1:0] exp_count();
`ifdef FETCH_CYCLE_COUNT_EN
    return m_cnt;
`else
    return '0;
`endif
  endfunction

  function automatic logic [W-1:0] pack_model();
    logic [1:0] st;
    st = 2'(m_state);
    return {exp_count(), m_pc, (m_state == 1), (m_state == 2), m_fault, st};
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_pc    = '0;
    m_fault = 1'b0;
    m_cnt   = '0;
  endtask

  task automatic compare_outputs(input string tag);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_pc"},      32'(inst_address), 32'(e[W-CW-1 -: AW]));
    check({tag, "_running"}, 32'(running),      32'(e[4]));
    check({tag, "_done"},    32'(done),         32'(e[3]));
    check({tag, "_fault"},   32'(fault),        32'(e[2]));
    check({tag, "_state"},   32'(state_dbg),    32'(e[1:0]));
    check({tag, "_count"},   32'(cycle_count),  32'(e[W-1 -: CW]));
  endtask

  // Driver: apply one cycle of inputs, advance the model, push its prediction, then check after the edge
  task automatic step(input string tag, input logic st, input logic [AW-1:0] sa,
                      input logic sl, input logic br, input logic [AW-1:0] bt, input logic hr);
    start = st; start_addr = sa; stall = sl; branch_en = br; branch_target = bt; halt_req = hr;
    case (m_state)
      0, 2: begin
        if (st) begin
          m_state = 1; m_pc = sa; m_fault = 1'b0; m_cnt = '0;
        end
      end
      default: begin
        if (hr) begin
          m_state = 2;
        end else begin
          if (m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
          if (sl) begin
            m_pc = m_pc;
          end else if (br) begin
            m_pc = bt;
          end else begin
            if (m_pc == {AW{1'b1}}) m_fault = 1'b1;
            m_pc = m_pc + 1'b1;
          end
        end
      end
    endcase
    exp_q.push_back(pack_model());
    @(posedge clk);
    #1;
    compare_outputs(tag);
  endtask

  task automatic plain(input string tag);
    step(tag, 1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0; start_addr = '0; stall = 1'b0; branch_en = 1'b0; branch_target = '0; halt_req = 1'b0;
    model_reset();
    #2;
    exp_q.push_back(pack_model());
    compare_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Idle ignores everything but Start
    step("idle_hold", 1'b0, 11'h055, 1'b1, 1'b1, 11'h0AA, 1'b1);

    // Sequential fetch from 0x010 to 0x015
    step("start_010", 1'b1, 11'h010, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 5; i++) plain("seq");

    // Asynchronous reset in the middle of a cycle at PC=0x015
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    exp_q.push_back(pack_model());
    compare_outputs("async_reset");
    #2 rst_n = 1'b1;

    // Branch, stall+branch, halt+branch, restart from HALTED
    step("start_000", 1'b1, 11'h000, 1'b1, 1'b1, 11'h100, 1'b1);
    plain("seq_1");
    plain("seq_2");
    plain("seq_3");
    step("stall_branch", 1'b0, '0, 1'b1, 1'b1, 11'h001, 1'b0);
    step("branch_001", 1'b0, '0, 1'b0, 1'b1, 11'h001, 1'b0);
    step("start_ignored", 1'b1, 11'h300, 1'b0, 1'b0, '0, 1'b0);
    plain("seq_3b");
    plain("seq_4");
    step("halt_branch", 1'b0, '0, 1'b1, 1'b1, 11'h200, 1'b1);
    step("halted_hold", 1'b0, '0, 1'b0, 1'b1, 11'h200, 1'b0);

    // Wrap past the top of the ROM sets a sticky Fault; Start clears it
    step("start_7fe", 1'b1, 11'h7FE, 1'b0, 1'b0, '0, 1'b0);
    plain("wrap_7ff");
    plain("wrap_000");
    plain("wrap_001");
    step("halt_fault", 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    step("restart_clear", 1'b1, 11'h020, 1'b0, 1'b0, '0, 1'b0);

    // Cycle counter: 3 run + 2 stall cycles, then halt; value frozen in HALTED
    step("cnt_start", 1'b1, 11'h100, 1'b0, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) plain("cnt_run");
    for (int i = 0; i < 2; i++) step("cnt_stall", 1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
    step("cnt_halt", 1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
    step("cnt_frozen", 1'b0, '0, 1'b1, 1'b1, 11'h010, 1'b0);
    check("cnt_five", 32'(cycle_count), 32'(exp_count()));

    // Random mix of all inputs
    for (int i = 0; i < 60; i++) begin
      step("rand",
           ($urandom_range(0, 5) == 0),
           AW'($urandom_range(0, 2047)),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 3) == 0),
           AW'($urandom_range(0, 2047)),
           ($urandom_range(0, 9) == 0));
    end

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
